// File: rtl/dmem_store_buffer.sv
// Posted-write store buffer in front of data_mem: stores queue in a FIFO and drain in the
// background; loads wait for the FIFO to empty, then issue one read through the same FSM.
module dmem_store_buffer #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cpu_memread,
    input  logic        cpu_memwrite,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic [3:0]  cpu_sign_mask,
    output logic        cpu_stall,
    output logic [31:0] cpu_rdata,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_sign_mask,
    output logic        mem_memwrite,
    output logic        mem_memread,
    input  logic        mem_busy,
    input  logic [31:0] mem_rdata
);

    localparam int unsigned CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  sign_mask;
    } entry_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_HI,
        S_WAIT_LO,
        S_DONE
    } state_t;

    entry_t           fifo_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q, count_d;
    state_t           state_q, state_d;
    logic             is_read_q, is_read_d;
    logic [31:0]      mem_addr_q, mem_addr_d;
    logic [31:0]      mem_wdata_q, mem_wdata_d;
    logic [3:0]       mem_sign_mask_q, mem_sign_mask_d;
    logic             mem_memwrite_q, mem_memwrite_d;
    logic             mem_memread_q, mem_memread_d;
    logic [31:0]      cpu_rdata_q, cpu_rdata_d;
    logic             push, pop, full, load_req;
    entry_t           head;

    assign full     = (count_q == CNT_W'(DEPTH));
    assign push     = cpu_memwrite && !full;
    assign load_req = cpu_memread && !cpu_memwrite;
    assign head     = fifo_q[rd_ptr_q];

    // Gated by reset so the CPU sees no stall while the block is held in reset.
    assign cpu_stall = reset_n && ((cpu_memwrite && full) ||
                                   (load_req && (state_q != S_DONE)));

    assign cpu_rdata     = cpu_rdata_q;
    assign mem_addr      = mem_addr_q;
    assign mem_wdata     = mem_wdata_q;
    assign mem_sign_mask = mem_sign_mask_q;
    assign mem_memwrite  = mem_memwrite_q;
    assign mem_memread   = mem_memread_q;

    // FIFO storage carries no reset; validity is tracked by count_q.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= '{addr: cpu_addr, wdata: cpu_wdata, sign_mask: cpu_sign_mask};
        end
    end

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            count_q         <= '0;
            state_q         <= S_IDLE;
            is_read_q       <= 1'b0;
            mem_addr_q      <= '0;
            mem_wdata_q     <= '0;
            mem_sign_mask_q <= '0;
            mem_memwrite_q  <= 1'b0;
            mem_memread_q   <= 1'b0;
            cpu_rdata_q     <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q         <= count_d;
            state_q         <= state_d;
            is_read_q       <= is_read_d;
            mem_addr_q      <= mem_addr_d;
            mem_wdata_q     <= mem_wdata_d;
            mem_sign_mask_q <= mem_sign_mask_d;
            mem_memwrite_q  <= mem_memwrite_d;
            mem_memread_q   <= mem_memread_d;
            cpu_rdata_q     <= cpu_rdata_d;
        end
    end

    // Drain FSM: buffered stores take priority; a load issues only once the FIFO is empty.
    always_comb begin
        state_d         = state_q;
        is_read_d       = is_read_q;
        mem_addr_d      = mem_addr_q;
        mem_wdata_d     = mem_wdata_q;
        mem_sign_mask_d = mem_sign_mask_q;
        mem_memwrite_d  = 1'b0;
        mem_memread_d   = 1'b0;
        cpu_rdata_d     = cpu_rdata_q;
        pop             = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!mem_busy && (count_q != '0)) begin
                    mem_addr_d      = head.addr;
                    mem_wdata_d     = head.wdata;
                    mem_sign_mask_d = head.sign_mask;
                    mem_memwrite_d  = 1'b1;
                    is_read_d       = 1'b0;
                    state_d         = S_ISSUE;
                end else if (!mem_busy && load_req) begin
                    mem_addr_d      = cpu_addr;
                    mem_wdata_d     = cpu_wdata;
                    mem_sign_mask_d = cpu_sign_mask;
                    mem_memread_d   = 1'b1;
                    is_read_d       = 1'b1;
                    state_d         = S_ISSUE;
                end
            end
            S_ISSUE: state_d = S_WAIT_HI;
            S_WAIT_HI: begin
                if (mem_busy) state_d = S_WAIT_LO;
            end
            S_WAIT_LO: begin
                if (!mem_busy) begin
                    if (is_read_q) begin
                        cpu_rdata_d = mem_rdata;
                        state_d     = S_DONE;
                    end else begin
                        pop     = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_dmem_store_buffer.sv
// Bench for dmem_store_buffer: a data_mem responder with variable busy time, plus a
// reference of expected memory traffic and memory contents built from accepted requests.
module tb_dmem_store_buffer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cpu_memread, cpu_memwrite;
    logic [31:0] cpu_addr, cpu_wdata;
    logic [3:0]  cpu_sign_mask;
    logic        cpu_stall;
    logic [31:0] cpu_rdata;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_sign_mask;
    logic        mem_memwrite, mem_memread;
    logic        mem_busy = 1'b0;
    logic [31:0] mem_rdata = '0;

    int total = 0;
    int bad   = 0;
    int lat   = 3;
    int busy_left = 0;

    // Entries: {is_read, addr, data, sign_mask}
    logic [68:0] exp_q [$];
    logic [68:0] log_q [$];
    int          chk_idx = 0;
    logic [31:0] tbmem   [logic [31:0]];
    logic [31:0] ref_mem [logic [31:0]];

    dmem_store_buffer #(.DEPTH(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .cpu_memread(cpu_memread), .cpu_memwrite(cpu_memwrite),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_sign_mask(cpu_sign_mask),
        .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_sign_mask(mem_sign_mask),
        .mem_memwrite(mem_memwrite), .mem_memread(mem_memread),
        .mem_busy(mem_busy), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rd_tb(input logic [31:0] a);
        return tbmem.exists(a) ? tbmem[a] : 32'h0;
    endfunction

    function automatic logic [31:0] rd_ref(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
    endfunction

    // data_mem stand-in: no reset, busy for 'lat' cycles after each strobe.
    always @(negedge clk) begin
        if (mem_busy) begin
            if (busy_left == 0) mem_busy = 1'b0;
            else busy_left--;
        end
        if (mem_memwrite) begin
            tbmem[mem_addr] = mem_wdata;
            log_q.push_back({1'b0, mem_addr, mem_wdata, mem_sign_mask});
            mem_busy  = 1'b1;
            busy_left = lat - 1;
        end
        if (mem_memread) begin
            mem_rdata = rd_tb(mem_addr);
            log_q.push_back({1'b1, mem_addr, mem_rdata, mem_sign_mask});
            mem_busy  = 1'b1;
            busy_left = lat - 1;
        end
    end

    task automatic check(input string tag, input logic [68:0] obs, input logic [68:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m,
                         output int stalls);
        bit ok = 0;
        cpu_memwrite = 1'b1; cpu_addr = a; cpu_wdata = d; cpu_sign_mask = m;
        stalls = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (!cpu_stall) begin ok = 1; break; end
            stalls++;
        end
        if (!ok) check("store_timeout", 69'd0, 69'd1);
        exp_q.push_back({1'b0, a, d, m});
        ref_mem[a] = d;
        @(posedge clk); #1;
        cpu_memwrite = 1'b0;
    endtask

    task automatic load(input logic [31:0] a, input logic [3:0] m,
                        output logic [31:0] rd, output int stalls);
        bit ok = 0;
        cpu_memread = 1'b1; cpu_addr = a; cpu_sign_mask = m;
        exp_q.push_back({1'b1, a, rd_ref(a), m});
        stalls = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (!cpu_stall) begin ok = 1; break; end
            stalls++;
        end
        if (!ok) check("load_timeout", 69'd0, 69'd1);
        rd = cpu_rdata;
        @(posedge clk); #1;
        cpu_memread = 1'b0;
    endtask

    task automatic wait_idle();
        int quiet = 0;
        for (int i = 0; i < 1000 && quiet < 3; i++) begin
            @(posedge clk); #1;
            if (log_q.size() == exp_q.size() && !mem_busy) quiet++;
            else quiet = 0;
        end
        if (quiet < 3) check("idle_timeout", 69'd0, 69'd1);
    endtask

    task automatic compare_log();
        for (int i = chk_idx; i < exp_q.size(); i++) begin
            check("mem_traffic", (i < log_q.size()) ? log_q[i] : 69'h0, exp_q[i]);
        end
        check("traffic_count", 69'(log_q.size()), 69'(exp_q.size()));
        chk_idx = exp_q.size();
    endtask

    initial begin
        int          st;
        int          st5;
        logic [31:0] rd;
        logic [5:0]  stall_pat, rd_pat;
        int          log_at_reset;

        // Reset held with random inputs
        reset_n = 1'b0;
        cpu_memread = 1'b0; cpu_memwrite = 1'b0;
        cpu_addr = '0; cpu_wdata = '0; cpu_sign_mask = '0;
        for (int i = 0; i < 4; i++) begin
            cpu_memread   = 1'($urandom);
            cpu_memwrite  = 1'($urandom);
            cpu_addr      = $urandom;
            cpu_wdata     = $urandom;
            cpu_sign_mask = 4'($urandom);
            @(negedge clk);
            check("rst_stall", 69'(cpu_stall), 69'd0);
            check("rst_mem_out", {mem_addr, mem_wdata, mem_sign_mask, mem_memwrite},
                  69'd0);
            check("rst_rd", {mem_memread, cpu_rdata}, 69'd0);
        end
        cpu_memread = 1'b0; cpu_memwrite = 1'b0;
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("post_rst_strobe", {mem_memwrite, mem_memread}, 69'd0);
        end
        @(posedge clk); #1;

        // Single store: strobe appears once the entry is in the FIFO and the FSM sees it
        lat = 3;
        store(32'h1004, 32'hDEADBEEF, 4'b0100, st);
        check("st1_stall", 69'(st), 69'd0);
        @(negedge clk);
        check("st1_c1_strobe", 69'(mem_memwrite), 69'd0);
        @(negedge clk);
        check("st1_c2_strobe", {mem_memwrite, mem_memread, mem_addr, mem_wdata, mem_sign_mask},
              {2'b10, 32'h1004, 32'hDEADBEEF, 4'b0100});
        @(negedge clk);
        check("st1_c3_strobe", 69'(mem_memwrite), 69'd0);
        @(posedge clk); #1;
        wait_idle();
        compare_log();

        // Five back-to-back stores against a 4-entry FIFO
        lat = 2;
        for (int k = 0; k < 5; k++) begin
            store(32'h1100 + 32'(4 * k), $urandom, 4'($urandom), st);
            if (k < 4) check("b2b_nostall", 69'(st), 69'd0);
            else st5 = st;
        end
        check("b2b_5th_stalled", 69'(st5 > 0), 69'd1);
        wait_idle();
        compare_log();

        // Load after store waits for the drain (no forwarding needed)
        lat = 3;
        store(32'h1008, 32'h12345678, 4'b1111, st);
        load(32'h1008, 4'b1111, rd, st);
        check("raw_rdata", 69'(rd), 69'h12345678);
        check("raw_waited", 69'(st > 5), 69'd1);
        wait_idle();
        compare_log();

        // Load with empty FIFO: stall cycles 0-4, read strobe cycle 1, data in cycle 5
        lat = 3;
        cpu_memread = 1'b1; cpu_addr = 32'h1004; cpu_sign_mask = 4'b1111;
        exp_q.push_back({1'b1, 32'h1004, rd_ref(32'h1004), 4'b1111});
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            stall_pat[c] = cpu_stall;
            rd_pat[c]    = mem_memread;
            if (c == 5) rd = cpu_rdata;
        end
        @(posedge clk); #1;
        cpu_memread = 1'b0;
        check("ld_stall_pattern", 69'(stall_pat), 69'b011111);
        check("ld_strobe_pattern", 69'(rd_pat), 69'b000010);
        check("ld_rdata", 69'(rd), 69'hDEADBEEF);
        wait_idle();
        compare_log();

        // Randomized mix of stores (including the LED address) and loads
        for (int n = 0; n < 40; n++) begin
            int          k;
            logic [31:0] a;
            lat = $urandom_range(2, 4);
            k = $urandom_range(0, 8);
            a = (k == 8) ? 32'h2000 : 32'h1000 + 32'(4 * k);
            if ($urandom_range(0, 2) < 2) begin
                store(a, $urandom, 4'($urandom), st);
            end else begin
                logic [31:0] want;
                want = rd_ref(a);
                load(a, 4'b1111, rd, st);
                check("rand_load", 69'(rd), 69'(want));
            end
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
        end
        wait_idle();
        compare_log();

        // Reset while a write waits on data_mem with three entries buffered
        lat = 8;
        for (int k = 0; k < 3; k++) store(32'h1200 + 32'(4 * k), $urandom, 4'hF, st);
        for (int i = 0; i < 50 && !mem_busy; i++) begin
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        log_at_reset = log_q.size();
        reset_n = 1'b0;
        #1;
        check("midrst_outputs", {mem_memwrite, mem_memread, cpu_stall, mem_addr, mem_wdata},
              69'd0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        check("midrst_mem_still_busy", 69'(mem_busy), 69'd1);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("midrst_no_strobe", {mem_memwrite, mem_memread}, 69'd0);
        end
        check("midrst_fifo_lost", 69'(log_q.size()), 69'(log_at_reset));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
